// File: rtl/scale_ctrl_pkg.sv
// Shared types and constants for the scaling-engine sequencer.
package scale_ctrl_pkg;

  localparam int ADDR_W = 16;
  localparam int PIX_W  = 8;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_OPCODE  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/scale_wr_pipe.sv
// DEPTH-stage shift register carrying {valid, addr} so framebuffer writes line up
// with the source memory's read latency; flush drops everything in flight.
module scale_wr_pipe
  import scale_ctrl_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      addr_q[0]  <= addr_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign addr_o  = addr_q[DEPTH-1];

endmodule

// File: rtl/scale_ctrl.sv
// Sequencer and framebuffer-port owner for the image-scaling engines.
// Define SCALE_CTRL_TIMEOUT_EN to add the RUN-state timeout counter.
module scale_ctrl
  import scale_ctrl_pkg::*;
#(
  parameter int NUM_ENG     = 4,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [2:0]                cmd_op,
  output logic [NUM_ENG-1:0]        eng_enable,
  input  logic [NUM_ENG-1:0]        eng_done,
  input  logic [ADDR_W*NUM_ENG-1:0] eng_read_addr,
  input  logic [ADDR_W*NUM_ENG-1:0] eng_write_addr,
  input  logic [PIX_W*NUM_ENG-1:0]  eng_pixel_out,
  output logic [ADDR_W-1:0]         mem_rd_addr,
  output logic [ADDR_W-1:0]         mem_wr_addr,
  output logic [PIX_W-1:0]          mem_wr_data,
  output logic                      mem_wr_en,
  output logic                      fb_busy,
  output logic                      op_done,
  output logic [1:0]                err_code
);

  state_t            state_q, state_d;
  logic [2:0]        sel_q, sel_d;
  logic [1:0]        err_q, err_d;
  logic [2:0]        drainCnt_q, drainCnt_d;
  logic              flush;
  logic              inRun;
  logic              timeoutHit;
  logic [ADDR_W-1:0] selRdAddr, selWrAddr;
  logic [PIX_W-1:0]  selPixel;
  logic              selDone;
  logic              pipeValid;
  logic [ADDR_W-1:0] pipeAddr;

  assign inRun = (state_q == ST_RUN);

  always_comb begin
    selRdAddr = '0;
    selWrAddr = '0;
    selPixel  = '0;
    selDone   = 1'b0;
    for (int i = 0; i < NUM_ENG; i++) begin
      if (sel_q == 3'(i)) begin
        selRdAddr = eng_read_addr[i*ADDR_W +: ADDR_W];
        selWrAddr = eng_write_addr[i*ADDR_W +: ADDR_W];
        selPixel  = eng_pixel_out[i*PIX_W +: PIX_W];
        selDone   = eng_done[i];
      end
    end
  end

`ifdef SCALE_CTRL_TIMEOUT_EN
  logic [15:0] toCnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       toCnt_q <= '0;
    else if (!inRun) toCnt_q <= '0;
    else             toCnt_q <= toCnt_q + 16'd1;
  end

  assign timeoutHit = inRun && (toCnt_q == 16'(TIMEOUT_CYC - 1));
`else
  assign timeoutHit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      err_q      <= ERR_OK;
      drainCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      err_q      <= err_d;
      drainCnt_q <= drainCnt_d;
    end
  end

  // A completed engine outranks a timeout that lands on the same cycle.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    err_d      = err_q;
    drainCnt_d = drainCnt_q;
    flush      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          sel_d = cmd_op;
          if (32'(cmd_op) >= NUM_ENG) begin
            err_d   = ERR_OPCODE;
            state_d = ST_DONE;
          end else begin
            err_d   = ERR_OK;
            state_d = ST_ARM;
          end
        end
      end
      ST_ARM: state_d = ST_RUN;
      ST_RUN: begin
        if (selDone) begin
          drainCnt_d = '0;
          state_d    = ST_DRAIN;
        end else if (timeoutHit) begin
          flush   = 1'b1;
          err_d   = ERR_TIMEOUT;
          state_d = ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (drainCnt_q == 3'(RD_LAT - 1)) state_d = ST_DONE;
        else                              drainCnt_d = drainCnt_q + 3'd1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  scale_wr_pipe #(.DEPTH(RD_LAT)) u_wr_pipe (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .valid_i (inRun && !selDone && !flush),
    .addr_i  (inRun ? selWrAddr : '0),
    .valid_o (pipeValid),
    .addr_o  (pipeAddr)
  );

  always_comb begin
    eng_enable = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      eng_enable[i] = inRun && (sel_q == 3'(i));
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign mem_rd_addr = inRun ? selRdAddr : '0;
  assign mem_wr_en   = pipeValid;
  assign mem_wr_addr = pipeAddr;
  assign mem_wr_data = pipeValid ? selPixel : '0;
  assign op_done     = (state_q == ST_DONE);
  assign err_code    = op_done ? err_q : ERR_OK;
  // A rejected opcode never touches the framebuffer, so the display stays free.
  assign fb_busy     = (state_q != ST_IDLE) && !(op_done && (err_q == ERR_OPCODE));

endmodule

// File: tb/tb_scale_ctrl.sv
// Self-checking bench for scale_ctrl: behavioural engines and a latency ROM,
// with per-cycle expectations derived from the operation timeline.
module tb_scale_ctrl;

  localparam int NE = 4;
  localparam int L  = 3;
  localparam int TO = 100;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            cmd_valid = 1'b0;
  logic [2:0]      cmd_op = 3'd0;
  logic            cmd_ready;
  logic [NE-1:0]   eng_enable;
  logic [NE-1:0]   eng_done;
  logic [16*NE-1:0] eng_read_addr;
  logic [16*NE-1:0] eng_write_addr;
  logic [8*NE-1:0] eng_pixel_out;
  logic [15:0]     mem_rd_addr, mem_wr_addr;
  logic [7:0]      mem_wr_data;
  logic            mem_wr_en, fb_busy, op_done;
  logic [1:0]      err_code;

  int          vectors = 0;
  int          miscompares = 0;
  int          engN [NE];
  logic [15:0] rb [NE];
  logic [15:0] wb [NE];
  logic [15:0] cnt [NE];
  logic [15:0] hist [4];
  logic        spur = 1'b0;

  always #5 clk = ~clk;

  scale_ctrl #(.NUM_ENG(NE), .RD_LAT(L), .TIMEOUT_CYC(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .eng_enable     (eng_enable),
    .eng_done       (eng_done),
    .eng_read_addr  (eng_read_addr),
    .eng_write_addr (eng_write_addr),
    .eng_pixel_out  (eng_pixel_out),
    .mem_rd_addr    (mem_rd_addr),
    .mem_wr_addr    (mem_wr_addr),
    .mem_wr_data    (mem_wr_data),
    .mem_wr_en      (mem_wr_en),
    .fb_busy        (fb_busy),
    .op_done        (op_done),
    .err_code       (err_code)
  );

  function automatic logic [7:0] rom(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
  endfunction

  // Each engine walks its frame from zero while enabled and passes memory data through.
  always_comb begin
    eng_read_addr  = '0;
    eng_write_addr = '0;
    eng_pixel_out  = '0;
    eng_done       = '0;
    for (int i = 0; i < NE; i++) begin
      eng_read_addr[i*16 +: 16]  = rb[i] + cnt[i];
      eng_write_addr[i*16 +: 16] = wb[i] + cnt[i];
      eng_pixel_out[i*8 +: 8]    = rom(hist[L-1]) ^ 8'(i * 17);
      eng_done[i]                = (32'(cnt[i]) >= engN[i]) || (i == 2 && spur);
    end
  end

  always @(posedge clk) begin
    hist[0] <= mem_rd_addr;
    for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
    for (int i = 0; i < NE; i++) begin
      if (!eng_enable[i])               cnt[i] <= '0;
      else if (32'(cnt[i]) < engN[i])   cnt[i] <= cnt[i] + 16'd1;
    end
  end

  function automatic logic [63:0] vec(input logic rdy, input logic [3:0] en, input logic busy,
                                      input logic opd, input logic [1:0] err, input logic wr,
                                      input logic [15:0] a, input logic [7:0] d);
    return {30'd0, rdy, en, busy, opd, err, wr, a, d};
  endfunction

  function automatic logic [63:0] dutVec(input bit mask);
    logic [15:0] a;
    logic [7:0]  d;
    a = (mask && !mem_wr_en) ? 16'd0 : mem_wr_addr;
    d = (mask && !mem_wr_en) ? 8'd0 : mem_wr_data;
    return vec(cmd_ready, eng_enable, fb_busy, op_done, err_code, mem_wr_en, a, d);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one command and check every cycle from accept until the port is free again.
  task automatic applyStimulus(input logic [2:0] op, input int n, input bit hold,
                               input bit spurEn, input bit tmo, input int abortAt,
                               input string tag);
    bit          bad, wr;
    int          doneCyc, lastRun, last, k;
    logic [63:0] exp;
    bad = (int'(op) >= NE);
    if (!bad) begin
      rb[op]   = 16'($urandom);
      wb[op]   = 16'($urandom);
      engN[op] = n;
    end
    lastRun = tmo ? 1 + TO : 2 + n;
    doneCyc = bad ? 1 : (tmo ? 2 + TO : 3 + n + L);
    last    = doneCyc + 1;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      k = c - 2 - L;
      if (bad) begin
        exp = vec(c != 1, 4'd0, 1'b0, c == 1, (c == 1) ? 2'd1 : 2'd0, 1'b0, 16'd0, 8'd0);
      end else begin
        wr  = (k >= 0) && (tmo ? (c <= lastRun) : (k < n));
        exp = vec(c == 0 || c > doneCyc,
                  (c >= 2 && c <= lastRun) ? 4'(1 << op) : 4'd0,
                  c >= 1 && c <= doneCyc,
                  c == doneCyc,
                  (c == doneCyc) ? (tmo ? 2'd2 : 2'd0) : 2'd0,
                  wr,
                  wr ? wb[op] + 16'(k) : 16'd0,
                  wr ? rom(rb[op] + 16'(k)) ^ 8'(op * 17) : 8'd0);
      end
      checkOutput(tag, dutVec(1'b1), exp);
      cmd_valid = (c == 0) || (hold && c < last);
      cmd_op    = op;
      spur      = spurEn && c >= 3 && c < 12;
      if (c == abortAt) begin
        cmd_valid = 1'b0;
        spur      = 1'b0;
        return;
      end
    end
    spur = 1'b0;
  endtask

  task automatic resetPhase(input int cycles, input string tag);
    reset = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      #1;
      checkOutput(tag, dutVec(1'b0), vec(1'b1, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 8'd0));
      @(negedge clk);
    end
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NE; i++) begin
      engN[i] = 1;
      rb[i]   = 16'd0;
      wb[i]   = 16'd0;
      cnt[i]  = 16'd0;
    end
    #1;
    resetPhase(3, "reset");

    applyStimulus(3'd0, 4800, 1'b0, 1'b0, 1'b0, -1, "decimate");
    applyStimulus(3'd5, 0, 1'b0, 1'b0, 1'b0, -1, "badop5");
    applyStimulus(3'd4, 0, 1'b0, 1'b0, 1'b0, -1, "badop4");
    applyStimulus(3'd7, 0, 1'b1, 1'b0, 1'b0, -1, "badop7");
    applyStimulus(3'd3, 1, 1'b0, 1'b0, 1'b0, -1, "op3-n1");
    applyStimulus(3'd2, 0, 1'b0, 1'b0, 1'b0, -1, "op2-n0");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'($urandom_range(0, NE - 1)), int'($urandom_range(1, 300)),
                    ($urandom_range(0, 1) == 1), 1'b0, 1'b0, -1, "random");
    end
    applyStimulus(3'd0, 500, 1'b1, 1'b1, 1'b0, -1, "hold-spur");

    applyStimulus(3'd1, 4800, 1'b0, 1'b0, 1'b0, 2 + L + 2000, "pre-reset");
    resetPhase(5, "mid-reset");
    applyStimulus(3'd1, 4800, 1'b0, 1'b0, 1'b0, -1, "post-reset");

`ifdef SCALE_CTRL_TIMEOUT_EN
    applyStimulus(3'd2, 65535, 1'b0, 1'b0, 1'b1, -1, "timeout");
`else
    engN[1] = 60000;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 3'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      checkOutput("no-timeout", {63'd0, op_done}, 64'd0);
    end
    resetPhase(2, "final-reset");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
